data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Responder end of the data-memory request/response interface used by the pipeline's MEM stage. It accepts one load or store request at a time through a valid/ready handshake, models a configurable access latency, performs the access on an internal word array with byte enables, and returns the read data and error status through a second valid/ready handshake. It sits behind the EX/MEM barrier in place of a zero-latency memory. The MEM stage stalls while a request is outstanding.

## Interface
- `WORD_COUNT`, 256: number of 32-bit words; power of two.
- `WAIT_CYCLES`, 2: extra cycles between request acceptance and the array access; range 0–15.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `reqValid` in 1: request present.
- `reqReady` out 1: responder can accept a request.
- `reqWrite` in 1: 1 = store, 0 = load.
- `reqAddress` in 32: byte address.
- `reqWriteData` in 32: store data.
- `reqByteEnable` in 4: store byte lanes; bit i enables byte i (bits 8i+7:8i).
- `respValid` out 1: response present.
- `respReady` in 1: requester accepts the response.
- `respReadData` out 32: load data; 0 for stores and errors.
- `respError` out 1: access was misaligned or out of range.

## Operation
- State machine with three states: IDLE, WAIT, RESPOND.
  - In IDLE, `reqReady` is 1. `reqValid && reqReady` at an edge latches write, address, data and byte enables, and loads the wait counter with `WAIT_CYCLES`.
    - If `WAIT_CYCLES` is 0, the FSM goes to WAIT with the counter at 0.
  - In WAIT, `reqReady` is 0.
    - Counter != 0: decrement.
    - Counter == 0: perform the access and go to RESPOND.
      - The access sets `respValid`, `respReadData` and `respError`.
  - In RESPOND, `respValid` is 1, and `respReadData` and `respError` are held stable until `respReady` is 1 at an edge. Then the FSM goes to IDLE, `respValid` goes to 0 and `respReadData` clears to 0.
- Word index is `reqAddress[log2(WORD_COUNT)+1:2]`.
- Error cases:
  - `reqAddress[1:0] != 0` is an error.
  - `reqAddress >= 4*WORD_COUNT` is an error.
  - On error the array is not modified and `respReadData` is 0.
- Store: only the enabled byte lanes are written. `respReadData` is 0.
  - A store with `reqByteEnable` = 0 is legal, leaves the array unchanged and reports no error.
- Load: returns the full 32-bit word; byte enables are ignored.
- Request inputs are sampled only at acceptance. Changes to them while in WAIT or RESPOND have no effect.
- `reqValid` while not ready is held off; nothing is dropped or queued. Any queuing is the requester's responsibility.

## Timing
- Reset values, applied asynchronously:
  - state IDLE
  - `reqReady` 1
  - `respValid` 0
  - `respReadData` 0
  - `respError` 0
  - counter 0
- Reset does not clear array contents.
- `reqReady`, `respValid`, `respReadData` and `respError` are registered outputs; none is combinational from the inputs.
- Latency: a request accepted at edge N gives `respValid` = 1 after edge N+`WAIT_CYCLES`+1.
- Minimum request spacing is `WAIT_CYCLES`+3 edges, because IDLE is re-entered for at least one cycle after the response handshake.
- `respReady` held at 1 before `respValid` rises completes the response handshake at the first edge where `respValid` is 1.
- Reset asserted mid-transaction aborts the transaction.
  - A store whose array write has not yet occurred is discarded.
  - A store already written stays written.
  - No response is produced.
- The array write happens on the same edge as the WAIT→RESPOND transition. A following load therefore observes the stored data.

## Structure
- Package `data_memory_pkg` holds:
  - the state enum (IDLE, WAIT, RESPOND);
  - the counter width constant (4 bits);
  - the byte-lane count constant (4).
- Sub-module `byte_enable_ram`: synchronous single-port `WORD_COUNT`×32 array.
  - Ports: write enable, 4-bit byte enable, word index, write data, read data.
  - Read data is registered.
  - The responder's FSM, counter and error checks stay in the top block.

## Test plan
- Reset, then store 0xDEADBEEF at 0x10 with `reqByteEnable` = 4'hF, then load 0x10 with `WAIT_CYCLES`=2.
  - Each `respValid` rises 3 edges after acceptance.
  - Load returns 0xDEADBEEF with `respError`=0.
- Store 0x000000AA at 0x10 with `reqByteEnable` = 4'b0001, then load 0x10 → 0xDEADBEAA.
- Load 0x12 (misaligned) and load 4*`WORD_COUNT` → `respError`=1 and `respReadData`=0; a subsequent load of 0x10 is unchanged.
- Hold `respReady`=0 for 5 cycles after `respValid` rises.
  - `respValid`, data and error stay stable, and `reqReady` stays 0.
  - Release `respReady` → handshake on that edge, IDLE on the next.
- Assert `reset` in WAIT during a store to 0x20.
  - Outputs go to reset values immediately and no response follows.
  - A later load of 0x20 returns the pre-store contents.
- With `WAIT_CYCLES`=0, drive `reqValid` and `respReady` continuously with alternating stores and loads to 0x40.
  - Accept and response spacing is exactly 3 edges.
  - Every load returns the preceding store's data.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared types and constants for the data-memory responder.
package data_memory_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRespond
  } state_t;

  localparam int unsigned CounterWidth = 4;
  localparam int unsigned ByteLanes    = 4;

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface data_memory_responder_if;
  import data_memory_pkg::*;

  logic                 reqValid;
  logic                 reqReady;
  logic                 reqWrite;
  logic [31:0]          reqAddress;
  logic [31:0]          reqWriteData;
  logic [ByteLanes-1:0] reqByteEnable;
  logic                 respValid;
  logic                 respReady;
  logic [31:0]          respReadData;
  logic                 respError;

  modport master (
    output reqValid, reqWrite, reqAddress, reqWriteData, reqByteEnable, respReady,
    input  reqReady, respValid, respReadData, respError
  );

  modport slave (
    input  reqValid, reqWrite, reqAddress, reqWriteData, reqByteEnable, respReady,
    output reqReady, respValid, respReadData, respError
  );

endinterface

// File: rtl/byte_enable_ram.sv
// Single-port word array with per-byte write enables and a registered read port.
module byte_enable_ram
  import data_memory_pkg::*;
#(
  parameter int unsigned WORD_COUNT = 256
) (
  input  logic                          clk,
  input  logic                          writeEnable,
  input  logic [ByteLanes-1:0]          byteEnable,
  input  logic [$clog2(WORD_COUNT)-1:0] wordIndex,
  input  logic [31:0]                   writeData,
  output logic [31:0]                   readData
);

  logic [31:0] mem [WORD_COUNT];

  // Read-before-write: readData reflects the word as it was before this edge.
  always_ff @(posedge clk) begin
    if (writeEnable) begin
      for (int i = 0; i < int'(ByteLanes); i++) begin
        if (byteEnable[i]) begin
          mem[wordIndex][8*i +: 8] <= writeData[8*i +: 8];
        end
      end
    end
    readData <= mem[wordIndex];
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: one outstanding request, fixed wait latency, registered response.
module data_memory_responder
  import data_memory_pkg::*;
#(
  parameter int unsigned WORD_COUNT  = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  data_memory_responder_if.slave  bus
);

  localparam int unsigned IndexWidth = $clog2(WORD_COUNT);

  state_t                  stateQ, stateD;
  logic [CounterWidth-1:0] cntQ, cntD;
  logic                    writeQ;
  logic [31:0]             addrQ;
  logic [31:0]             dataQ;
  logic [ByteLanes-1:0]    beQ;
  logic                    loadOkQ;
  logic                    errorQ;
  logic [31:0]             ramReadData;

  logic accept;
  logic access;
  logic addrError;

  assign accept    = (stateQ == StIdle) && bus.reqValid;
  assign access    = (stateQ == StWait) && (cntQ == '0);
  assign addrError = (addrQ[1:0] != 2'b00) || (addrQ[31:IndexWidth+2] != '0);

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    unique case (stateQ)
      StIdle: begin
        if (bus.reqValid) begin
          stateD = StWait;
          cntD   = CounterWidth'(WAIT_CYCLES);
        end
      end
      StWait: begin
        if (cntQ != '0) begin
          cntD = cntQ - 4'd1;
        end else begin
          stateD = StRespond;
        end
      end
      StRespond: begin
        if (bus.respReady) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ  <= StIdle;
      cntQ    <= '0;
      writeQ  <= 1'b0;
      addrQ   <= '0;
      dataQ   <= '0;
      beQ     <= '0;
      loadOkQ <= 1'b0;
      errorQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      if (accept) begin
        writeQ <= bus.reqWrite;
        addrQ  <= bus.reqAddress;
        dataQ  <= bus.reqWriteData;
        beQ    <= bus.reqByteEnable;
      end
      if (access) begin
        loadOkQ <= !writeQ && !addrError;
        errorQ  <= addrError;
      end else if ((stateQ == StRespond) && bus.respReady) begin
        loadOkQ <= 1'b0;
        errorQ  <= 1'b0;
      end
    end
  end

  // The RAM captures the addressed word on the access edge and keeps recapturing
  // the same (unchanging) word while responding; loadOkQ gates it onto the bus.
  byte_enable_ram #(
    .WORD_COUNT(WORD_COUNT)
  ) u_ram (
    .clk        (clk),
    .writeEnable(access && writeQ && !addrError),
    .byteEnable (beQ),
    .wordIndex  (addrQ[IndexWidth+1:2]),
    .writeData  (dataQ),
    .readData   (ramReadData)
  );

  assign bus.reqReady     = (stateQ == StIdle);
  assign bus.respValid    = (stateQ == StRespond);
  assign bus.respReadData = loadOkQ ? ramReadData : 32'h0;
  assign bus.respError    = errorQ;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: stimulus tasks queue expected responses, negedge monitors check them.
module tb_data_memory_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   lastResp0 = -1;
  exp_t q2[$];
  exp_t q0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_responder_if bus2 ();
  data_memory_responder_if bus0 ();

  data_memory_responder #(
    .WORD_COUNT (256),
    .WAIT_CYCLES(2)
  ) dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2)
  );

  data_memory_responder #(
    .WORD_COUNT (256),
    .WAIT_CYCLES(0)
  ) dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Handshake completes at the posedge following a negedge that sees valid && ready.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus2.respValid === 1'b1 && bus2.respReady === 1'b1) begin
      exp_t e;
      if (q2.size() == 0) begin
        check32("dut2 unexpected response", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        check32("dut2 resp data", bus2.respReadData, e.data);
        check32("dut2 resp err", {31'b0, bus2.respError}, {31'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0 && bus0.respValid === 1'b1 && bus0.respReady === 1'b1) begin
      exp_t e;
      if (lastResp0 >= 0) check32("dut0 resp spacing", 32'(cyc - lastResp0), 32'd3);
      lastResp0 = cyc;
      if (q0.size() == 0) begin
        check32("dut0 unexpected response", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        check32("dut0 resp data", bus0.respReadData, e.data);
        check32("dut0 resp err", {31'b0, bus0.respError}, {31'b0, e.err});
      end
    end
  end

  task automatic req2(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be, input logic [31:0] expData, input logic expErr,
                      input int hold);
    int n;
    int acc;
    @(negedge clk);
    bus2.reqWrite      = wr;
    bus2.reqAddress    = addr;
    bus2.reqWriteData  = data;
    bus2.reqByteEnable = be;
    bus2.reqValid      = 1'b1;
    bus2.respReady     = (hold == 0);
    n = 0;
    while (!bus2.reqReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus2.reqReady) begin
      check32("req accept timeout", 32'd1, 32'd0);
      bus2.reqValid = 1'b0;
      return;
    end
    q2.push_back('{expData, expErr});
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    // Garbage on the request lines must not affect the outstanding access.
    bus2.reqValid      = 1'b0;
    bus2.reqWrite      = ~wr;
    bus2.reqAddress    = 32'h0000_0044;
    bus2.reqWriteData  = ~data;
    bus2.reqByteEnable = 4'hF;
    n = 0;
    while (!bus2.respValid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check32("resp latency", 32'(cyc - acc), 32'd3);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        check32("hold valid", {31'b0, bus2.respValid}, 32'd1);
        check32("hold data", bus2.respReadData, expData);
        check32("hold err", {31'b0, bus2.respError}, {31'b0, expErr});
        check32("hold reqReady", {31'b0, bus2.reqReady}, 32'd0);
        @(negedge clk);
      end
      @(posedge clk);
      #1 bus2.respReady = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check32("post-handshake valid", {31'b0, bus2.respValid}, 32'd0);
      check32("post-handshake data", bus2.respReadData, 32'h0);
      check32("post-handshake reqReady", {31'b0, bus2.reqReady}, 32'd1);
    end else begin
      n = 0;
      while (bus2.respValid && n < 40) begin
        @(negedge clk);
        n++;
      end
      check32("idle after resp", {31'b0, bus2.reqReady}, 32'd1);
    end
  endtask

  initial begin
    int  n;
    int  prevAcc;
    logic [31:0] lastStore;
    logic seenResp;
    bus2.reqValid = 1'b0; bus2.reqWrite = 1'b0; bus2.reqAddress = '0;
    bus2.reqWriteData = '0; bus2.reqByteEnable = '0; bus2.respReady = 1'b1;
    bus0.reqValid = 1'b0; bus0.reqWrite = 1'b0; bus0.reqAddress = '0;
    bus0.reqWriteData = '0; bus0.reqByteEnable = '0; bus0.respReady = 1'b1;

    #1 reset = 1'b1;
    #2;
    check32("rst reqReady", {31'b0, bus2.reqReady}, 32'd1);
    check32("rst respValid", {31'b0, bus2.respValid}, 32'd0);
    check32("rst data", bus2.respReadData, 32'h0);
    check32("rst err", {31'b0, bus2.respError}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    req2(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
    req2(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
    req2(1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0, 0);
    req2(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 0);
    req2(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 0);
    req2(1'b0, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1, 0);
    req2(1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1, 0);
    req2(1'b1, 32'h13, 32'h12345678, 4'hF, 32'h0, 1'b1, 0);
    req2(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 5);

    // Reset mid-WAIT discards a pending store and produces no response.
    req2(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 0);
    @(negedge clk);
    bus2.reqWrite = 1'b1; bus2.reqAddress = 32'h20;
    bus2.reqWriteData = 32'h55667788; bus2.reqByteEnable = 4'hF;
    bus2.reqValid = 1'b1; bus2.respReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus2.reqValid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check32("abort reqReady", {31'b0, bus2.reqReady}, 32'd1);
    check32("abort respValid", {31'b0, bus2.respValid}, 32'd0);
    check32("abort data", bus2.respReadData, 32'h0);
    check32("abort err", {31'b0, bus2.respError}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seenResp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus2.respValid) seenResp = 1'b1;
    end
    check32("no resp after abort", {31'b0, seenResp}, 32'd0);
    req2(1'b0, 32'h20, 32'h0, 4'h0, 32'h11223344, 1'b0, 0);

    // Back-to-back traffic on the zero-wait instance.
    prevAcc = -1;
    lastStore = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus0.reqValid      = 1'b1;
      bus0.reqWrite      = (i % 2 == 0);
      bus0.reqAddress    = 32'h40;
      bus0.reqWriteData  = 32'hA5A5_0000 + 32'(i * 257);
      bus0.reqByteEnable = 4'hF;
      n = 0;
      while (!bus0.reqReady && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!bus0.reqReady) begin
        check32("dut0 accept timeout", 32'd1, 32'd0);
        break;
      end
      if (i % 2 == 0) begin
        lastStore = 32'hA5A5_0000 + 32'(i * 257);
        q0.push_back('{32'h0, 1'b0});
      end else begin
        q0.push_back('{lastStore, 1'b0});
      end
      @(posedge clk);
      @(negedge clk);
      if (prevAcc >= 0) check32("dut0 accept spacing", 32'(cyc - prevAcc), 32'd3);
      prevAcc = cyc;
    end
    bus0.reqValid = 1'b0;

    n = 0;
    while ((q0.size() != 0 || q2.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check32("dut2 queue drained", 32'(q2.size()), 32'd0);
    check32("dut0 queue drained", 32'(q0.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
